// File: rtl/seq_shift_right_if.sv
// ----------------------------------------------------------------------------
// seq_shift_right_if
//   Bundles the start/busy/done handshake and data of the multi-cycle right
//   shifter.
//
//   Handshake: the controller raises `start` with A/Amt/Arith stable. The
//   shifter samples `start` only while idle. It raises `busy` while shifting
//   and pulses `done` for exactly one cycle when Result/CarryOut are final.
//   Result/CarryOut then hold until the next accepted start. `start` seen
//   while busy or done is dropped and is not remembered.
//
//   Signals:
//     start    controller -> shifter  request pulse
//     A[7:0]   controller -> shifter  operand
//     Amt[2:0] controller -> shifter  shift count 0..7
//     Arith    controller -> shifter  0 = logical, 1 = arithmetic
//     Result   shifter -> controller  shift register contents
//     CarryOut shifter -> controller  last bit shifted out of bit 0
//     busy     shifter -> controller  high while shifting
//     done     shifter -> controller  one-cycle completion strobe
//
//   Modports: master = controller side, slave = shifter side.
// ----------------------------------------------------------------------------
interface seq_shift_right_if;
  logic       start;
  logic [7:0] A;
  logic [2:0] Amt;
  logic       Arith;
  logic [7:0] Result;
  logic       CarryOut;
  logic       busy;
  logic       done;

  modport master (
    output start, A, Amt, Arith,
    input  Result, CarryOut, busy, done
  );

  modport slave (
    input  start, A, Amt, Arith,
    output Result, CarryOut, busy, done
  );
endinterface

// File: rtl/seq_shift_right.sv
// ----------------------------------------------------------------------------
// seq_shift_right
//   Multi-cycle 8-bit right shifter. It captures the operand, the shift count
//   and the mode on an accepted start. It then shifts one bit position per
//   clock, in logical or arithmetic mode, and flags completion with a
//   one-cycle done strobe.
//
//   Ports:
//     clk          system clock, rising edge
//     reset        asynchronous, active-high; clears all state immediately
//     bus          seq_shift_right_if.slave (start/A/Amt/Arith in,
//                  Result/CarryOut/busy/done out)
//     o_dbg_state  current FSM state (0 = IDLE, 1 = SHIFT, 2 = DONE)
//
//   All outputs come straight from registers. No input reaches an output
//   through combinational logic.
// ----------------------------------------------------------------------------
module seq_shift_right (
  input  logic                   clk,
  input  logic                   reset,
  seq_shift_right_if.slave       bus,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_shreg;
  logic [2:0] r_count;
  logic       r_fill;
  logic       r_carry;
  logic       r_busy;
  logic       r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shreg <= 8'h00;
      r_count <= 3'd0;
      r_fill  <= 1'b0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (bus.start) begin
            r_shreg <= bus.A;
            r_count <= bus.Amt;
            // The sign is latched once here. Later changes on A have no effect.
            r_fill  <= bus.Arith & bus.A[7];
            r_carry <= 1'b0;
            if (bus.Amt != 3'd0) begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              // A zero shift skips SHIFT, so busy never rises.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          r_carry <= r_shreg[0];
          r_shreg <= {r_fill, r_shreg[7:1]};
          // The count is never 0 in this state. The <= guard still stops an
          // underflow if the state is ever corrupted.
          if (r_count <= 3'd1) begin
            r_count <= 3'd0;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count - 3'd1;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Result   = r_shreg;
  assign bus.CarryOut = r_carry;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_seq_shift_right.sv
module tb_seq_shift_right;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  seq_shift_right_if u_if ();

  seq_shift_right dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (u_if.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [8:0] exp_q[$];   // {Result, CarryOut}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [2:0] amt,
                                       input logic arith);
    logic [7:0] v;
    logic       c;
    logic       f;
    v = a;
    c = 1'b0;
    f = arith & a[7];
    for (int k = 0; k < int'(amt); k++) begin
      c = v[0];
      v = {f, v[7:1]};
    end
    return {v, c};
  endfunction

  // ---------------- driver ----------------
  // Runs one operation and checks latency, busy, the result and the
  // behaviour after done. With inject set, it also pulses start with garbage
  // operands while the shifter is busy and during the done cycle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [2:0] amt,
                        input logic arith, input logic [8:0] exp, input bit inject);
    int         busy_n;
    int         lat;
    bit         got;
    logic [8:0] e;
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.A     = a;
    u_if.Amt   = amt;
    u_if.Arith = arith;
    exp_q.push_back(exp);
    @(negedge clk);               // E0 has passed
    u_if.start = 1'b0;
    if (inject) begin
      u_if.A = 8'hFF; u_if.Amt = 3'd7; u_if.Arith = 1'b1;
    end
    busy_n = 0;
    lat    = 0;
    got    = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (u_if.busy && u_if.done) chk({tag, "_busy_and_done"}, 1, 0);
      if (u_if.busy) begin
        busy_n++;
        if (inject) u_if.start = ~u_if.start;
      end
      if (u_if.done) begin
        got = 1'b1;
        lat = c;
        if (inject) u_if.start = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk({tag, "_done_timeout"}, 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_result"}, {24'd0, u_if.Result}, {24'd0, e[8:1]});
    chk({tag, "_carry"}, {31'd0, u_if.CarryOut}, {31'd0, e[0]});
    chk({tag, "_latency"}, lat, {29'd0, amt});
    chk({tag, "_busy_cycles"}, busy_n, {29'd0, amt});
    // Result must hold in IDLE, and no second done pulse may follow.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      u_if.start = 1'b0;
      chk({tag, "_post_done"}, {30'd0, u_if.done, u_if.busy}, 0);
      chk({tag, "_post_result"}, {23'd0, u_if.Result, u_if.CarryOut}, {23'd0, e});
    end
    chk({tag, "_idle_state"}, {30'd0, dbg_state}, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] a;
    logic [2:0] amt;
    logic       arith;
    logic [7:0] exp_r;
    logic       exp_c;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'hB4, 3'd3, 1'b0, 8'h16, 1'b1};
    vecs[1] = '{8'hB4, 3'd3, 1'b1, 8'hF6, 1'b1};
    vecs[2] = '{8'h81, 3'd7, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h81, 3'd7, 1'b0, 8'h01, 1'b0};
    vecs[4] = '{8'h5A, 3'd0, 1'b0, 8'h5A, 1'b0};
    vecs[5] = '{8'h7F, 3'd1, 1'b1, 8'h3F, 1'b1};
    vecs[6] = '{8'hC3, 3'd2, 1'b1, 8'hF0, 1'b1};
    vecs[7] = '{8'h55, 3'd5, 1'b0, 8'h02, 1'b1};
    vecs[8] = '{8'hFF, 3'd0, 1'b1, 8'hFF, 1'b0};
    vecs[9] = '{8'h80, 3'd7, 1'b0, 8'h01, 1'b0};

    checks = 0;
    errors = 0;
    reset      = 1'b1;
    u_if.start = 1'b0;
    u_if.A     = 8'h00;
    u_if.Amt   = 3'd0;
    u_if.Arith = 1'b0;

    // Reset state, checked before any clock edge.
    #3;
    chk("reset_result", {24'd0, u_if.Result}, 0);
    chk("reset_flags", {29'd0, u_if.CarryOut, u_if.busy, u_if.done}, 0);
    chk("reset_state", {30'd0, dbg_state}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // With start held low, nothing changes.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_hold", {21'd0, u_if.Result, u_if.CarryOut, u_if.busy, u_if.done}, 0);
    end

    // Table-driven vectors.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].amt, vecs[i].arith,
             {vecs[i].exp_r, vecs[i].exp_c}, 1'b0);

    // Start pulses during SHIFT and DONE must be ignored.
    run_op("ignored_start", 8'h80, 3'd4, 1'b0, {8'h08, 1'b0}, 1'b1);

    // Reset in the second SHIFT cycle of a long operation.
    @(negedge clk);
    u_if.start = 1'b1; u_if.A = 8'hF0; u_if.Amt = 3'd6; u_if.Arith = 1'b0;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("mid_busy_before_reset", {31'd0, u_if.busy}, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_result", {24'd0, u_if.Result}, 0);
    chk("mid_reset_flags", {29'd0, u_if.CarryOut, u_if.busy, u_if.done}, 0);
    chk("mid_reset_state", {30'd0, dbg_state}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_reset_no_done", {30'd0, u_if.busy, u_if.done}, 0);
    end
    run_op("after_reset", 8'h40, 3'd2, 1'b0, {8'h10, 1'b0}, 1'b0);

    // Random operations checked against the reference shift model.
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra;
      logic [2:0] rm;
      logic       rs;
      ra = 8'($urandom_range(0, 255));
      rm = 3'($urandom_range(0, 7));
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rm, rs, model(ra, rm, rs), 1'b0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shift_right.md
# seq_shift_right

Multi-cycle right shifter for the lab09 datapath, the opposite-direction companion of the single-step left-shift compute unit. It accepts an 8-bit operand and a 3-bit shift amount on a start pulse, shifts one bit position per clock (logical or arithmetic), then presents the result with a one-cycle done strobe. It sits beside the combinational compute units and is sequenced by the lab controller through a start/busy/done handshake.

## Interface
- No parameters; width fixed at 8 bits, shift amount fixed at 3 bits.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request pulse; sampled only in IDLE
- A  input  8  operand, captured on the accepted start edge
- Amt  input  3  shift count 0–7, captured on the accepted start edge
- Arith  input  1  0 = logical (shift in 0), 1 = arithmetic (shift in captured A[7]), captured on the accepted start edge
- Result  output  8  shift register contents; final result valid while done=1 and held until next accepted start
- CarryOut  output  1  last bit shifted out of bit 0; 0 when Amt=0
- busy  output  1  high while in SHIFT
- done  output  1  high for exactly one cycle in DONE

## Operation
- States: IDLE, SHIFT, DONE. Internal: 8-bit shift reg (drives Result), 3-bit count, sign-fill bit.
- IDLE: start=1 at edge -> shift reg=A, count=Amt, fill=Arith&A[7], CarryOut=0; next state SHIFT if Amt≠0, else DONE.
- SHIFT: each edge -> CarryOut=reg[0], reg={fill, reg[7:1]}, count=count−1; when count goes 1->0, next state DONE.
- DONE: done=1 for one cycle; next edge -> IDLE unconditionally.
- start while in SHIFT or DONE is ignored (not queued); A/Amt/Arith changes after capture have no effect.
- Result and CarryOut hold their values in IDLE until the next accepted start.
- Fill bit is the captured sign, constant for the whole operation (Amt=7 arithmetic on negative operand yields 0xFF).
- No wrap: count never underflows; Amt=0 skips SHIFT entirely.

## Timing
- Reset (asserted at any time, including mid-SHIFT): state=IDLE, Result=0x00, CarryOut=0, busy=0, done=0, count=0, without waiting for clk. First start accepted on the first rising edge after reset deasserts.
- Start accepted at edge E0. Shifts occur at edges E1..EAmt. DONE is entered at edge EAmt (E0 when Amt=0), so done is high during the cycle following edge EAmt.
- Latency start-edge to done-high: Amt cycles (done visible Amt+... i.e. one cycle after E0 when Amt=0); total occupancy Amt+1 cycles before IDLE.
- busy high from after E0 through edge EAmt when Amt≠0; never high when Amt=0. busy and done never high together.
- Back-to-back: earliest next start accepted at the edge that returns DONE->IDLE plus one (i.e. first edge while in IDLE).
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then idle: reset=1 -> Result=0x00, CarryOut=0, busy=0, done=0; start held low -> no change.
- Logical: A=0xB4, Amt=3, Arith=0 -> busy 3 cycles, then done=1 with Result=0x16, CarryOut=1; Result holds in IDLE.
- Arithmetic: A=0xB4, Amt=3, Arith=1 -> Result=0xF6, CarryOut=1; A=0x81, Amt=7, Arith=1 -> Result=0xFF, CarryOut=0; same with Arith=0 -> Result=0x01, CarryOut=0.
- Zero shift: A=0x5A, Amt=0 -> busy never high, done high the cycle after start edge, Result=0x5A, CarryOut=0.
- Ignored start: start pulses with A=0xFF during SHIFT and DONE of an A=0x80, Amt=4 logical op -> Result=0x08, CarryOut=0, exactly one done pulse.
- Reset mid-operation: reset asserted in second SHIFT cycle of A=0xF0, Amt=6 -> outputs clear asynchronously, no done; new start A=0x40, Amt=2 after release -> Result=0x10, CarryOut=0.
